rxbuf: RTL and testbench
========================

# rxbuf

UART receive buffer: the receiving counterpart of the TXBUF transmit stage, consuming the serial line that TXBUF drives. It deserialises 11-bit frames (start, DATA_BIT data bits LSB-first, even parity, stop) at the same `clkdiv` bit timing TXBUF uses, then checks parity and stop bit. Received bytes and their error flags go into an ITEM_COUNT-deep first-word-fall-through FIFO. Both loopback on the board and the external host path drive its `rx` input.

## Interface
- DATA_BIT, 8, data bits per frame; frame is DATA_BIT+3 bits
- ITEM_COUNT, 4, FIFO depth in entries (power of two)
- clk  input  1  system clock
- resetN  input  1  asynchronous active-low reset
- clkdiv  input  16  bit period is clkdiv+1 clocks; must be ≥3; latched at start detection
- rx  input  1  serial line, idle high, asynchronous to clk
- readEnable  input  1  pop FIFO head when rxValid=1
- clearOverrun  input  1  synchronous clear of sticky overrun
- rxData  output  DATA_BIT  data of FIFO head; valid while rxValid=1
- rxValid  output  1  FIFO not empty
- parityError  output  1  head entry failed even parity
- frameError  output  1  head entry had stop bit = 0
- overrun  output  1  sticky: a frame was dropped because the FIFO was full
- itemCount  output  $clog2(ITEM_COUNT)+1  entries held
- led  output  DATA_BIT  data of the most recently stored frame

## Operation
- `rx` passes through a 2-flop synchroniser; both flops reset to 1. All logic below uses the synchronised `rxS`.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: on `rxS`=0, latch clkdiv into `div`, clear the counters, go to START.
- START: count to div>>1 (mid start bit), then sample `rxS`:
  - 0: go to DATA and restart the counter.
  - 1: glitch; return to IDLE and store nothing.
- DATA: sample every div+1 clocks. DATA_BIT data samples shift into the shift register LSB-first; the next sample is the parity bit. Then go to STOP.
- STOP: sample after div+1 clocks. Push {data, parityError = ^data ^ parity, frameError = ~stop}.
  - Stop = 1: go to IDLE. The block rearms from mid-stop, so back-to-back frames are accepted.
  - Stop = 0: go to BREAK.
- BREAK: wait for `rxS`=1, then go to IDLE. No start detection until then.
- FIFO: circular buffer of {frameError, parityError, data}. Head is shown combinationally from registered storage.
  - Pop when readEnable && rxValid. readEnable while empty is ignored.
  - Push while full with no pop in the same cycle: frame dropped, overrun ← 1. The frame is not written and led is not updated.
  - Push and pop in the same cycle while full: both succeed, itemCount unchanged, no overrun.
  - Push and pop in the same cycle otherwise: itemCount unchanged.
- overrun: set has priority over clearOverrun in the same cycle.
- led: updated on every successful push, including entries with errors.
- Arithmetic: pointers wrap modulo ITEM_COUNT. itemCount saturates structurally at ITEM_COUNT and never wraps.

## Timing
- Reset values (async, on resetN=0): state IDLE, FIFO empty, itemCount=0, rxValid=0, rxData=0, parityError=0, frameError=0, overrun=0, led=0.
- Reset mid-frame: the partial frame is discarded and the FIFO is cleared.
- After reset release, the first start is detectable 2 clocks after `rx` falls (synchroniser latency).
- Let E be the cycle `rxS` is first 0 in IDLE:
  - start sampled at E+1+(div>>1);
  - bit k (k=1..DATA_BIT+2) sampled at start sample + k·(div+1);
  - push takes effect on the clock edge after the stop sample, so rxValid/itemCount update 1 cycle after the stop sample.
- Pop: rxData/flags show the next entry the cycle after the readEnable edge. itemCount also decrements in that cycle.
- No combinational path from rx to any output.

## Test plan
- Clean frame, clkdiv=15: send 0xA5 (parity 0, stop 1). Required: itemCount=1, rxValid=1, rxData=0xA5, parityError=0, frameError=0, led=0xA5, all 1 cycle after the stop sample.
- Parity: send 0x01 with parity bit 0. Required: rxData=0x01, parityError=1, frameError=0. Then readEnable for 1 cycle → rxValid=0, itemCount=0.
- Framing/break: send 0x3C with stop=0, hold rx low 40 clocks, then send 0x55. Required: first entry 0x3C with frameError=1; no spurious entry during the low hold; second entry 0x55 with no errors.
- Glitch: rx low for 3 clocks with clkdiv=15. Required: no push, state back to IDLE, itemCount=0.
- Overrun: send 0x10..0x14 without reading. Required: itemCount=4, overrun=1, led=0x13; pops return 0x10,0x11,0x12,0x13.
  - Repeat with readEnable asserted in the cycle of the 5th push. Required: overrun stays 0, 0x14 is stored.
  - clearOverrun in a cycle with no drop → overrun=0.
- Reset mid-frame: assert resetN=0 during the data bits of 0xFF, release, then send 0x42. Required: only 0x42 stored, itemCount=1, led=0x42.

Source files
------------

// File: rtl/rxbuf_if.sv
// Signal bundle for the UART receive buffer: serial line, clock divider,
// FIFO read handshake and receive status.
interface rxbuf_if #(
  parameter int DATA_BIT   = 8,
  parameter int ITEM_COUNT = 4
);
  logic [15:0]                 clkdiv;
  logic                        rx;
  logic                        readEnable;
  logic                        clearOverrun;
  logic [DATA_BIT-1:0]         rxData;
  logic                        rxValid;
  logic                        parityError;
  logic                        frameError;
  logic                        overrun;
  logic [$clog2(ITEM_COUNT):0] itemCount;
  logic [DATA_BIT-1:0]         led;

  modport slave (
    input  clkdiv, rx, readEnable, clearOverrun,
    output rxData, rxValid, parityError, frameError, overrun, itemCount, led
  );

  modport master (
    output clkdiv, rx, readEnable, clearOverrun,
    input  rxData, rxValid, parityError, frameError, overrun, itemCount, led
  );
endinterface

// File: rtl/rxbuf.sv
// UART receiver (start, data LSB-first, even parity, stop) feeding a
// first-word-fall-through FIFO of {frameError, parityError, data}.
//   state   | meaning
//   S_IDLE  | line idle, waiting for rxS low
//   S_START | timing to mid start bit, rejects glitches
//   S_DATA  | sampling data bits, then the parity bit
//   S_STOP  | sampling stop bit, pushes the frame
//   S_BREAK | stop bit was low, waiting for line to return high
module rxbuf #(
  parameter int DATA_BIT   = 8,
  parameter int ITEM_COUNT = 4
) (
  input  logic   clk,
  input  logic   resetN,
  rxbuf_if.slave bus
);
  localparam int PW = $clog2(ITEM_COUNT);
  localparam int BW = $clog2(DATA_BIT + 1);
  localparam int EW = DATA_BIT + 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic rx_meta_q, rx_s_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  state_t              state_q, state_d;
  logic [15:0]         div_q, div_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_BIT-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic                push;
  logic                push_pe;
  logic                push_fe;
  logic                tc;

  assign tc = (cnt_q == 16'd0);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          div_d   = bus.clkdiv;
          cnt_d   = {1'b0, bus.clkdiv[15:1]};
          bit_d   = '0;
          shift_d = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tc) begin
          cnt_d   = div_q;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (tc) begin
          cnt_d = div_q;
          // the sample after the last data bit is the parity bit
          if (bit_q == BW'(DATA_BIT)) begin
            par_d   = rx_s_q;
            state_d = S_STOP;
          end else begin
            shift_d = {rx_s_q, shift_q[DATA_BIT-1:1]};
            bit_d   = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (tc) begin
          push    = 1'b1;
          state_d = rx_s_q ? S_IDLE : S_BREAK;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign push_pe = (^shift_q) ^ par_q;
  assign push_fe = ~rx_s_q;

  logic [EW-1:0]       mem_q [ITEM_COUNT];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW:0]         count_q, count_d;
  logic                overrun_q, overrun_d;
  logic [DATA_BIT-1:0] led_q, led_d;
  logic                full;
  logic                empty;
  logic                pop;
  logic                wr_en;
  logic                drop;
  logic [EW-1:0]       head;

  assign full  = (count_q == (PW+1)'(ITEM_COUNT));
  assign empty = (count_q == '0);
  assign pop   = bus.readEnable && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    led_d     = led_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      led_d    = shift_q;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    if (drop)                  overrun_d = 1'b1;
    else if (bus.clearOverrun) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < ITEM_COUNT; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      led_q     <= '0;
    end else begin
      if (wr_en) mem_q[wr_ptr_q] <= {push_fe, push_pe, shift_q};
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      led_q     <= led_d;
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign bus.rxData      = head[DATA_BIT-1:0];
  assign bus.parityError = head[DATA_BIT];
  assign bus.frameError  = head[DATA_BIT+1];
  assign bus.rxValid     = !empty;
  assign bus.itemCount   = count_q;
  assign bus.overrun     = overrun_q;
  assign bus.led         = led_q;
endmodule

// File: tb/tb_rxbuf.sv
// Bench for rxbuf: directed UART frames, expected FIFO entries queued at
// send time and checked by a monitor whenever an entry is popped.
module tb_rxbuf;
  localparam int DB = 8;
  localparam int IC = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;

  rxbuf_if #(.DATA_BIT(DB), .ITEM_COUNT(IC)) bus ();

  rxbuf #(.DATA_BIT(DB), .ITEM_COUNT(IC)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) sync();
  endtask

  // Monitor: every accepted pop must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (resetN && bus.readEnable && bus.rxValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got data 0x%0h expected no entry", bus.rxData);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pop_data", 32'(bus.rxData), 32'(e.d));
          chk("pop_parity_err", 32'(bus.parityError), 32'(e.pe));
          chk("pop_frame_err", 32'(bus.frameError), 32'(e.fe));
        end
      end
    end
  end

  // Drives one frame starting just after a rising edge. Stop sample cycle s
  // is counted from the first low drive: 2 sync flops + 1 + div>>1 + 10 bits.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input bit store, input bit tchk, input bit pop_at_s);
    logic [10:0] bits;
    int p;
    int s;
    int n0;
    p    = int'(bus.clkdiv) + 1;
    s    = 3 + int'(bus.clkdiv >> 1) + (DB + 2) * p;
    bits = {stp, par, d, 1'b0};
    n0   = exp_q.size();
    if (store) exp_q.push_back({d, (^d) ^ par, ~stp});
    for (int c = 0; c < 11 * p; c++) begin
      bus.rx = bits[c / p];
      if (pop_at_s) bus.readEnable = (c == s);
      if (tchk && (c == s || c == s + 1)) begin
        @(negedge clk);
        if (c == s) begin
          chk("count_at_stop_sample", 32'(bus.itemCount), 32'(n0));
        end else begin
          chk("count_after_push", 32'(bus.itemCount), 32'(n0 + 1));
          chk("valid_after_push", 32'(bus.rxValid), 32'd1);
        end
      end
      sync();
    end
    bus.readEnable = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      while (!bus.rxValid && t < 500) begin
        sync();
        t++;
      end
      if (!bus.rxValid) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: rxValid=0 required 1");
      end
      bus.readEnable = 1'b1;
      sync();
      bus.readEnable = 1'b0;
    end
  endtask

  task automatic chk_empty(input string name);
    @(negedge clk);
    chk({name, "_valid"}, 32'(bus.rxValid), 32'd0);
    chk({name, "_count"}, 32'(bus.itemCount), 32'd0);
    sync();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clkdiv       = 16'd15;
    bus.rx           = 1'b1;
    bus.readEnable   = 1'b0;
    bus.clearOverrun = 1'b0;
    resetN           = 1'b0;
    repeat (3) sync();
    @(negedge clk);
    chk("rst_count", 32'(bus.itemCount), 32'd0);
    chk("rst_valid", 32'(bus.rxValid), 32'd0);
    chk("rst_data", 32'(bus.rxData), 32'd0);
    chk("rst_parity_err", 32'(bus.parityError), 32'd0);
    chk("rst_frame_err", 32'(bus.frameError), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_led", 32'(bus.led), 32'd0);
    sync();
    resetN = 1'b1;
    idle(3);

    // clean frame with push timing
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("clean_data", 32'(bus.rxData), 32'hA5);
    chk("clean_parity_err", 32'(bus.parityError), 32'd0);
    chk("clean_frame_err", 32'(bus.frameError), 32'd0);
    chk("clean_led", 32'(bus.led), 32'hA5);
    sync();
    drain(1);
    chk_empty("clean_drained");

    // parity error
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("par_data", 32'(bus.rxData), 32'h01);
    chk("par_parity_err", 32'(bus.parityError), 32'd1);
    chk("par_frame_err", 32'(bus.frameError), 32'd0);
    sync();
    drain(1);
    chk_empty("par_drained");

    // shorter bit period
    bus.clkdiv = 16'd5;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("div5_led", 32'(bus.led), 32'h5A);
    sync();
    drain(1);
    bus.clkdiv = 16'd15;
    idle(2);

    // framing error, line held low, then a clean frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (40) sync();
    @(negedge clk);
    chk("break_count", 32'(bus.itemCount), 32'd1);
    chk("break_head_fe", 32'(bus.frameError), 32'd1);
    sync();
    idle(5);
    @(negedge clk);
    chk("break_no_spurious", 32'(bus.itemCount), 32'd1);
    sync();
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("after_break_count", 32'(bus.itemCount), 32'd2);
    sync();
    drain(2);
    chk_empty("break_drained");

    // start glitch
    bus.rx = 1'b0;
    repeat (3) sync();
    idle(30);
    chk_empty("glitch");

    // overrun: fifth frame dropped
    for (int i = 0; i < 5; i++) begin
      logic [7:0] d;
      d = 8'h10 + 8'(i);
      send_frame(d, ^d, 1'b1, (i < 4), 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("ovr_count", 32'(bus.itemCount), 32'd4);
    chk("ovr_flag", 32'(bus.overrun), 32'd1);
    chk("ovr_led", 32'(bus.led), 32'h13);
    sync();
    drain(4);
    @(negedge clk);
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);
    sync();
    chk_empty("ovr_drained");
    bus.clearOverrun = 1'b1;
    sync();
    bus.clearOverrun = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", 32'(bus.overrun), 32'd0);
    sync();

    // full FIFO, pop in the push cycle: fifth frame kept
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'h10 + 8'(i);
      send_frame(d, ^d, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    send_frame(8'h14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("swap_count", 32'(bus.itemCount), 32'd4);
    chk("swap_overrun", 32'(bus.overrun), 32'd0);
    chk("swap_led", 32'(bus.led), 32'h14);
    chk("swap_head", 32'(bus.rxData), 32'h11);
    sync();
    drain(4);
    chk_empty("swap_drained");

    // reset during a frame clears FIFO and partial frame
    send_frame(8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.rx = 1'b0;
    repeat (16) sync();
    bus.rx = 1'b1;
    repeat (40) sync();
    resetN = 1'b0;
    exp_q.delete();
    sync();
    @(negedge clk);
    chk("midrst_count", 32'(bus.itemCount), 32'd0);
    chk("midrst_led", 32'(bus.led), 32'd0);
    chk("midrst_data", 32'(bus.rxData), 32'd0);
    sync();
    resetN = 1'b1;
    idle(4);
    send_frame(8'h42, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(20);
    @(negedge clk);
    chk("midrst_after_count", 32'(bus.itemCount), 32'd1);
    chk("midrst_after_led", 32'(bus.led), 32'h42);
    sync();
    drain(1);
    chk_empty("final");
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
